// File: rtl/flash_status_poller.sv
// rtl/flash_status_poller.sv - RDSR polling sequencer that waits for the flash WIP bit to clear
// Optional abort input enabled by defining FLASH_POLLER_ABORT_EN.
module flash_status_poller #(
    parameter int         POLL_INTERVAL = 64,
    parameter int         MAX_POLLS     = 4096,
    parameter logic [7:0] RDSR_OPCODE   = 8'h05,
    parameter int         BUSY_BIT      = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_poll_start,
`ifdef FLASH_POLLER_ABORT_EN
    input  logic        in_poll_abort,
`endif
    output logic        out_poll_busy,
    output logic        out_poll_done,
    output logic        out_poll_timeout,
    output logic        out_flash_ready,
    output logic [7:0]  out_status_byte,
    output logic        out_spi_req,
    input  logic        in_spi_gnt,
    output logic        out_spi_start,
    output logic [15:0] out_spi_num_bytes,
    input  logic        in_spi_busy,
    input  logic        in_spi_done,
    output logic        out_spi_tx_valid,
    output logic [7:0]  out_spi_tx_data,
    input  logic        in_spi_tx_ready,
    input  logic        in_spi_rx_valid,
    input  logic [7:0]  in_spi_rx_data,
    output logic        out_spi_rx_ready
);

    localparam int PW = $clog2(MAX_POLLS) + 1;
    localparam int IW = $clog2(POLL_INTERVAL) + 1;
    localparam logic [PW-1:0] LAST_POLL  = PW'(MAX_POLLS - 1);
    localparam logic [IW-1:0] INT_RELOAD = IW'(POLL_INTERVAL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_START, S_TX_OP, S_TX_DUMMY, S_WAIT_DONE, S_CHECK, S_WAIT_INT
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] poll_cnt;
    logic [IW-1:0] int_cnt;
    logic [1:0]    rx_cnt;
    logic [7:0]    status_q;
    logic          flash_ready_q;
    logic          xfer_fail;
    logic          abort_req;
    logic          abort_pend;
    logic          in_xfer;
    logic          rx_take;

`ifdef FLASH_POLLER_ABORT_EN
    logic abort_q;
    assign abort_req  = in_poll_abort;
    assign abort_pend = abort_q | in_poll_abort;
`else
    assign abort_req  = 1'b0;
    assign abort_pend = 1'b0;
`endif

    assign in_xfer = (state == S_START) || (state == S_TX_OP) ||
                     (state == S_TX_DUMMY) || (state == S_WAIT_DONE);
    assign rx_take = in_xfer && in_spi_rx_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        out_spi_req       = 1'b0;
        out_spi_start     = 1'b0;
        out_spi_tx_valid  = 1'b0;
        out_spi_tx_data   = 8'h00;
        out_spi_rx_ready  = 1'b0;
        out_poll_done     = 1'b0;
        out_poll_timeout  = 1'b0;
        xfer_fail         = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_poll_start) state_nxt = S_REQ;
            end
            S_REQ: begin
                out_spi_req = 1'b1;
                if (abort_req) begin
                    out_poll_timeout = 1'b1;
                    state_nxt        = S_IDLE;
                end else if (in_spi_gnt && !in_spi_busy) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                out_spi_req      = 1'b1;
                out_spi_start    = 1'b1;
                out_spi_rx_ready = 1'b1;
                state_nxt        = S_TX_OP;
            end
            S_TX_OP, S_TX_DUMMY: begin
                out_spi_req      = 1'b1;
                out_spi_tx_valid = 1'b1;
                out_spi_tx_data  = (state == S_TX_OP) ? RDSR_OPCODE : 8'h00;
                out_spi_rx_ready = 1'b1;
                // A done before both bytes are sent means a truncated transfer.
                if (in_spi_done) begin
                    xfer_fail = 1'b1;
                    if (abort_pend) begin
                        out_poll_timeout = 1'b1;
                        state_nxt        = S_IDLE;
                    end else begin
                        state_nxt = S_CHECK;
                    end
                end else if (in_spi_tx_ready) begin
                    state_nxt = (state == S_TX_OP) ? S_TX_DUMMY : S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                out_spi_req      = 1'b1;
                out_spi_rx_ready = 1'b1;
                if (in_spi_done) begin
                    if (abort_pend) begin
                        out_poll_timeout = 1'b1;
                        state_nxt        = S_IDLE;
                    end else begin
                        state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if ((rx_cnt == 2'd2) && !status_q[BUSY_BIT]) begin
                    out_poll_done = 1'b1;
                    state_nxt     = S_IDLE;
                end else if (poll_cnt == LAST_POLL) begin
                    out_poll_timeout = 1'b1;
                    state_nxt        = S_IDLE;
                end else begin
                    state_nxt = S_WAIT_INT;
                end
            end
            S_WAIT_INT: begin
                if (abort_req) begin
                    out_poll_timeout = 1'b1;
                    state_nxt        = S_IDLE;
                end else if (int_cnt == '0) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_cnt      <= '0;
            int_cnt       <= '0;
            rx_cnt        <= 2'd0;
            status_q      <= 8'h00;
            flash_ready_q <= 1'b0;
        end else begin
            if (state == S_IDLE && in_poll_start) begin
                poll_cnt      <= '0;
                flash_ready_q <= 1'b0;
            end else if (out_poll_done) begin
                flash_ready_q <= 1'b1;
            end else if (out_poll_timeout) begin
                flash_ready_q <= 1'b0;
            end

            if (state == S_CHECK && state_nxt == S_WAIT_INT) begin
                poll_cnt <= poll_cnt + 1'b1;
                int_cnt  <= INT_RELOAD;
            end else if (state == S_WAIT_INT && int_cnt != '0) begin
                int_cnt <= int_cnt - 1'b1;
            end

            if (state == S_REQ || xfer_fail) begin
                rx_cnt <= 2'd0;
            end else if (rx_take && rx_cnt != 2'd2) begin
                rx_cnt <= rx_cnt + 2'd1;
            end

            // The first rx byte is clocked in during the opcode and carries no status.
            if (rx_take && rx_cnt == 2'd1) begin
                status_q <= in_spi_rx_data;
            end
        end
    end

`ifdef FLASH_POLLER_ABORT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abort_q <= 1'b0;
        end else if (state == S_IDLE) begin
            abort_q <= 1'b0;
        end else if (in_xfer && in_poll_abort) begin
            abort_q <= 1'b1;
        end
    end
`endif

    assign out_poll_busy     = (state != S_IDLE);
    assign out_flash_ready   = flash_ready_q;
    assign out_status_byte   = status_q;
    assign out_spi_num_bytes = in_xfer ? 16'd2 : 16'd0;

endmodule

// File: tb/tb_flash_status_poller.sv
// tb/tb_flash_status_poller.sv - directed self-checking bench for flash_status_poller
module tb_flash_status_poller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_poll_start = 1'b0;
`ifdef FLASH_POLLER_ABORT_EN
    logic        in_poll_abort = 1'b0;
`endif
    logic        out_poll_busy, out_poll_done, out_poll_timeout, out_flash_ready;
    logic [7:0]  out_status_byte;
    logic        out_spi_req;
    logic        in_spi_gnt = 1'b0;
    logic        out_spi_start;
    logic [15:0] out_spi_num_bytes;
    logic        in_spi_busy = 1'b0;
    logic        in_spi_done = 1'b0;
    logic        out_spi_tx_valid;
    logic [7:0]  out_spi_tx_data;
    logic        in_spi_tx_ready = 1'b0;
    logic        in_spi_rx_valid = 1'b0;
    logic [7:0]  in_spi_rx_data = 8'h00;
    logic        out_spi_rx_ready;

    always #5 clk = ~clk;

    flash_status_poller #(.POLL_INTERVAL(64), .MAX_POLLS(4)) dut (
        .clk(clk), .rst(rst), .in_poll_start(in_poll_start),
`ifdef FLASH_POLLER_ABORT_EN
        .in_poll_abort(in_poll_abort),
`endif
        .out_poll_busy(out_poll_busy), .out_poll_done(out_poll_done),
        .out_poll_timeout(out_poll_timeout), .out_flash_ready(out_flash_ready),
        .out_status_byte(out_status_byte), .out_spi_req(out_spi_req),
        .in_spi_gnt(in_spi_gnt), .out_spi_start(out_spi_start),
        .out_spi_num_bytes(out_spi_num_bytes), .in_spi_busy(in_spi_busy),
        .in_spi_done(in_spi_done), .out_spi_tx_valid(out_spi_tx_valid),
        .out_spi_tx_data(out_spi_tx_data), .in_spi_tx_ready(in_spi_tx_ready),
        .in_spi_rx_valid(in_spi_rx_valid), .in_spi_rx_data(in_spi_rx_data),
        .out_spi_rx_ready(out_spi_rx_ready)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_start = 0, n_done = 0, n_tmo = 0, n_both = 0;
    int last_start = 0, prev_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (out_spi_start) begin
            n_start    <= n_start + 1;
            last_start <= cyc;
            prev_start <= last_start;
        end
        if (out_poll_done) n_done <= n_done + 1;
        if (out_poll_timeout) n_tmo <= n_tmo + 1;
        if (out_poll_done && out_poll_timeout) n_both <= n_both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        in_poll_start = 1'b1;
        @(negedge clk);
        in_poll_start = 1'b0;
    endtask

    // mode 0: full 2-byte transfer; 1: only one rx byte; 2: done during the dummy byte.
    // Returns at the negedge of the CHECK cycle.
    task automatic xfer(input logic [7:0] s0, input logic [7:0] s1, input int mode);
        int w = 0;
        while (!out_spi_start && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("start_seen", out_spi_start, 1);
        chk("start_nbytes", out_spi_num_bytes, 16'd2);
        in_spi_tx_ready = 1'b1;
        @(negedge clk);
        chk("tx_op_valid", out_spi_tx_valid, 1);
        chk("tx_op_data", out_spi_tx_data, 8'h05);
        in_spi_rx_valid = 1'b1;
        in_spi_rx_data  = s0;
        @(negedge clk);
        chk("tx_dummy_data", {out_spi_tx_valid, out_spi_tx_data}, 9'h100);
        if (mode == 2) begin
            in_spi_tx_ready = 1'b0;
            in_spi_done     = 1'b1;
            in_spi_rx_data  = s1;
        end else if (mode == 1) begin
            in_spi_rx_valid = 1'b0;
        end else begin
            in_spi_rx_data = s1;
        end
        @(negedge clk);
        in_spi_tx_ready = 1'b0;
        in_spi_rx_valid = 1'b0;
        if (mode != 2) begin
            chk("wait_done_req", out_spi_req, 1);
            in_spi_done = 1'b1;
            @(negedge clk);
        end
        in_spi_done = 1'b0;
        chk("check_req_low", out_spi_req, 0);
    endtask

    initial begin
        int base, dbase, bad, gap;
        repeat (3) @(negedge clk);
        chk("rst_busy_req", {out_poll_busy, out_spi_req, out_spi_start}, 0);
        chk("rst_ready_status", {out_flash_ready, out_status_byte}, 0);
        chk("rst_pulses", {out_poll_done, out_poll_timeout, out_spi_tx_valid, out_spi_rx_ready}, 0);
        chk("rst_nbytes", out_spi_num_bytes, 0);
        rst = 1'b1;
        @(negedge clk);

        // Ready on first poll
        in_spi_gnt = 1'b1;
        pulse_start();
        chk("lat_req", {out_spi_req, out_poll_busy, out_spi_start}, 3'b110);
        @(negedge clk);
        chk("lat_start", out_spi_start, 1);
        xfer(8'hFF, 8'h00, 0);
        chk("t1_done", {out_poll_done, out_poll_timeout}, 2'b10);
        chk("t1_status", out_status_byte, 8'h00);
        @(negedge clk);
        chk("t1_ready_idle", {out_flash_ready, out_poll_busy, out_poll_done}, 3'b100);
        chk("t1_ndone", n_done, 1);

        // Busy then ready
        base = n_start;
        pulse_start();
        chk("t2_ready_cleared", out_flash_ready, 0);
        xfer(8'hFF, 8'h03, 0);
        chk("t2_status1", out_status_byte, 8'h03);
        chk("t2_nodone1", {out_poll_done, out_poll_timeout}, 0);
        xfer(8'hFF, 8'h03, 0);
        gap = last_start - prev_start;
        chk("t2_gap", gap >= 64, 1);
        xfer(8'hA5, 8'h02, 0);
        chk("t2_done", {out_poll_done, out_poll_timeout}, 2'b10);
        chk("t2_status3", out_status_byte, 8'h02);
        chk("t2_nstart", n_start - base, 3);
        @(negedge clk);
        chk("t2_ready", out_flash_ready, 1);

        // Timeout after MAX_POLLS
        base  = n_start;
        dbase = n_done;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            xfer(8'hFF, 8'h01, 0);
            chk("t3_tmo_pulse", out_poll_timeout, (i == 3) ? 1 : 0);
        end
        @(negedge clk);
        chk("t3_ready_busy", {out_flash_ready, out_poll_busy, out_poll_timeout}, 0);
        repeat (100) @(negedge clk);
        chk("t3_nstart", n_start - base, 4);
        chk("t3_no_done", n_done - dbase, 0);
        chk("t3_ntmo", n_tmo, 1);

        // Arbitration
        base = n_start;
        in_spi_gnt = 1'b0;
        pulse_start();
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 20) begin
                in_spi_gnt  = 1'b1;
                in_spi_busy = 1'b1;
            end
            in_poll_start = (i == 7);
            if (!out_spi_req || out_spi_start) bad++;
            @(negedge clk);
        end
        in_poll_start = 1'b0;
        chk("t4_req_held", bad, 0);
        in_spi_busy = 1'b0;
        @(negedge clk);
        chk("t4_start_after_gnt", out_spi_start, 1);
        xfer(8'hFF, 8'h00, 0);
        chk("t4_done", out_poll_done, 1);
        repeat (10) @(negedge clk);
        chk("t4_start_ignored", {out_poll_busy, 32'(n_start - base)}, 33'd1);

        // Short and truncated transactions count as busy
        base = n_start;
        pulse_start();
        xfer(8'hFF, 8'h00, 1);
        chk("t5_short_nodone", {out_poll_done, out_poll_timeout}, 0);
        xfer(8'hFF, 8'h00, 2);
        chk("t5_early_nodone", {out_poll_done, out_poll_timeout}, 0);
        gap = last_start - prev_start;
        chk("t5_gap", gap >= 64, 1);
        xfer(8'hFF, 8'h00, 0);
        chk("t5_done", out_poll_done, 1);
        chk("t5_nstart", n_start - base, 3);
        chk("both_never", n_both, 0);
        @(negedge clk);
        chk("t5_ready", out_flash_ready, 1);

        // Reset during TX_DUMMY
        pulse_start();
        @(negedge clk);
        in_spi_tx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_dummy", {out_spi_tx_valid, out_spi_tx_data}, 9'h100);
        rst = 1'b0;
        #1;
        chk("t6_rst_req_tx", {out_spi_req, out_spi_tx_valid}, 0);
        chk("t6_rst_busy_ready", {out_poll_busy, out_flash_ready}, 0);
        in_spi_tx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
